// File: rtl/pb_timer_pkg.sv
// Shared definitions for the PicoBlaze interval timer: register offsets,
// CTRL/STATUS bit positions and the default prescale ratio.
package pb_timer_defs;

    // Default number of CLK_IN cycles per timer tick
    localparam int unsigned PRESCALE_DEFAULT = 32'd100;

    // Register offsets relative to BASE_ADDR
    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
    localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
    localparam logic [2:0] OFF_STATUS    = 3'd3;
    localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
    localparam logic [2:0] OFF_COUNT_HI  = 3'd5;

    // Number of mapped registers in the block
    localparam logic [7:0] NUM_REGS = 8'd6;

    // CTRL and STATUS bit positions
    localparam int unsigned CTRL_EN_BIT    = 32'd0;
    localparam int unsigned CTRL_AUTO_BIT  = 32'd1;
    localparam int unsigned CTRL_IEN_BIT   = 32'd2;
    localparam int unsigned STATUS_EXP_BIT = 32'd0;

    // Pack the CTRL fields into the byte returned on a read
    function automatic logic [7:0] ctrl_byte(input logic en, input logic auto_rl, input logic ien);
        logic [7:0] b;
        b                = 8'h00;
        b[CTRL_EN_BIT]   = en;
        b[CTRL_AUTO_BIT] = auto_rl;
        b[CTRL_IEN_BIT]  = ien;
        return b;
    endfunction

    // Pack the STATUS fields into the byte returned on a read
    function automatic logic [7:0] status_byte(input logic exp_flag);
        logic [7:0] b;
        b                 = 8'h00;
        b[STATUS_EXP_BIT] = exp_flag;
        return b;
    endfunction

endpackage

// File: rtl/pb_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap cycle as
// a one-cycle tick. Held at zero while disabled so every enable starts a
// full prescale period.
module pb_tick_gen
    import pb_timer_defs::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic CLK_IN,
    input  logic RESET_IN,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 32'd1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;
    logic          wrap_s;

    // Next prescaler value and wrap detection
    always_comb begin
        wrap_s = enable && (cnt_q == LAST);
        if (!enable) begin
            cnt_d = '0;
        end else if (wrap_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler state register with synchronous active-low reset
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = wrap_s;

endmodule

// File: rtl/pb_timer.sv
// KCPSM6 port-mapped 16-bit down-counting interval timer with one-shot and
// auto-reload modes, a sticky expiry flag and an acknowledged interrupt.
module pb_timer
    import pb_timer_defs::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter int unsigned PRESCALE  = PRESCALE_DEFAULT
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic [7:0] PORT_ID,
    input  logic       WRITE_STROBE,
    input  logic       READ_STROBE,
    input  logic [7:0] OUT_PORT,
    output logic [7:0] IN_PORT,
    output logic       INTERRUPT,
    input  logic       INTERRUPT_ACK
);

    logic [8:0]  diff_s;
    logic        hit_s;
    logic [2:0]  off_s;
    logic        wr_s;
    logic        tick_s;

    logic        en_d, en_q;
    logic        auto_d, auto_q;
    logic        ien_d, ien_q;
    logic        exp_d, exp_q;
    logic        pend_d, pend_q;
    logic [15:0] reload_d, reload_q;
    logic [15:0] count_d, count_q;
    logic [7:0]  snap_d, snap_q;
    logic [7:0]  in_port_d, in_port_q;

    pb_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .CLK_IN   (CLK_IN),
        .RESET_IN (RESET_IN),
        .enable   (en_q),
        .tick     (tick_s)
    );

    // Address decode: borrow-checked offset from BASE_ADDR, hit only on mapped registers
    always_comb begin
        diff_s = {1'b0, PORT_ID} - {1'b0, BASE_ADDR};
        hit_s  = (diff_s[8] == 1'b0) && (diff_s[7:0] < NUM_REGS);
        off_s  = diff_s[2:0];
        wr_s   = WRITE_STROBE && hit_s && (off_s <= OFF_STATUS);
    end

    // Register file and counter next state; expiry sets win over same-cycle clears
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        ien_d    = ien_q;
        exp_d    = exp_q;
        pend_d   = pend_q;
        reload_d = reload_q;
        count_d  = count_q;
        snap_d   = snap_q;

        if (wr_s) begin
            case (off_s)
                OFF_CTRL: begin
                    en_d   = OUT_PORT[CTRL_EN_BIT];
                    auto_d = OUT_PORT[CTRL_AUTO_BIT];
                    ien_d  = OUT_PORT[CTRL_IEN_BIT];
                    // Only a 0->1 transition of EN restarts the count
                    if (!en_q && OUT_PORT[CTRL_EN_BIT]) begin
                        count_d = reload_q;
                    end else begin
                        count_d = count_q;
                    end
                    if (!OUT_PORT[CTRL_IEN_BIT]) begin
                        pend_d = 1'b0;
                    end else begin
                        pend_d = pend_q;
                    end
                end
                OFF_RELOAD_LO: reload_d[7:0]  = OUT_PORT;
                OFF_RELOAD_HI: reload_d[15:8] = OUT_PORT;
                OFF_STATUS:    exp_d = OUT_PORT[STATUS_EXP_BIT] ? 1'b0 : exp_q;
                default:       exp_d = exp_q;
            endcase
        end else begin
            exp_d = exp_q;
        end

        if (INTERRUPT_ACK) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_d;
        end

        if (tick_s) begin
            if (count_q != 16'h0000) begin
                count_d = count_q - 16'h0001;
            end else begin
                exp_d  = 1'b1;
                pend_d = ien_q ? 1'b1 : pend_d;
                if (auto_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end else begin
            count_d = count_d;
        end

        // Reading COUNT_LO freezes the high byte so a 16-bit read is coherent
        if (READ_STROBE && hit_s && (off_s == OFF_COUNT_LO)) begin
            snap_d = count_q[15:8];
        end else begin
            snap_d = snap_q;
        end
    end

    // Read-data mux, registered every cycle regardless of READ_STROBE
    always_comb begin
        in_port_d = 8'h00;
        if (hit_s) begin
            case (off_s)
                OFF_CTRL:      in_port_d = ctrl_byte(en_q, auto_q, ien_q);
                OFF_RELOAD_LO: in_port_d = reload_q[7:0];
                OFF_RELOAD_HI: in_port_d = reload_q[15:8];
                OFF_STATUS:    in_port_d = status_byte(exp_q);
                OFF_COUNT_LO:  in_port_d = count_q[7:0];
                OFF_COUNT_HI:  in_port_d = snap_q;
                default:       in_port_d = 8'h00;
            endcase
        end else begin
            in_port_d = 8'h00;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ien_q     <= 1'b0;
            exp_q     <= 1'b0;
            pend_q    <= 1'b0;
            reload_q  <= 16'h0000;
            count_q   <= 16'h0000;
            snap_q    <= 8'h00;
            in_port_q <= 8'h00;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            ien_q     <= ien_d;
            exp_q     <= exp_d;
            pend_q    <= pend_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            snap_q    <= snap_d;
            in_port_q <= in_port_d;
        end
    end

    assign IN_PORT   = in_port_q;
    assign INTERRUPT = pend_q;

endmodule
